button_conditioner: RTL and testbench

Conditions one raw board push-button into clean, single-cycle control events for the 12-hour clock top. It synchronises the asynchronous input, debounces it, and emits press/release pulses plus a long-press event with auto-repeat. PRESS drives the start/stop toggle, so one press gives exactly one toggle. HOLD/REPEAT drive time-set increments. One instance is used per button.

---
 rtl/button_conditioner.sv | 145 ++++++++++++++
 tb/tb_button_conditioner.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Turns one raw push-button into a debounced LEVEL and single-cycle PRESS/RELEASE/HOLD/REPEAT pulses.
// BTN to LEVEL/PRESS takes DEBOUNCE_CYCLES+2 edges; nothing here can be stalled, and pulses are never acknowledged.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 100_000_000,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic LEVEL,
    output logic PRESS,
    output logic RELEASE,
    output logic HOLD,
    output logic REPEAT
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          level_q, level_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    state_t        state_q, state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          hold_q, hold_d;
    logic          repeat_q, repeat_d;

    logic level_rise;
    logic level_fall;

    always_comb begin
        s1_d    = BTN;
        s2_d    = s1_q;
        level_d = level_q;
        dcnt_d  = '0;
        if (s2_q != level_q) begin
            if (dcnt_q == D_LAST) begin
                level_d = s2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    // The FSM reacts to the LEVEL value being registered this edge, so PRESS/RELEASE line up with LEVEL.
    assign level_rise = level_d & ~level_q;
    assign level_fall = ~level_d & level_q;

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        rcnt_d    = rcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        hold_d    = 1'b0;
        repeat_d  = 1'b0;
        if (level_fall) begin
            // A release wins over a HOLD/REPEAT threshold landing on the same edge.
            state_d   = ST_IDLE;
            release_d = 1'b1;
            hcnt_d    = '0;
            rcnt_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (level_rise) begin
                        state_d = ST_PRESSED;
                        press_d = 1'b1;
                        hcnt_d  = '0;
                    end
                end
                ST_PRESSED: begin
                    hcnt_d = hcnt_q + 1'b1;
                    if (hcnt_q == H_LAST) begin
                        state_d = ST_HELD;
                        hold_d  = 1'b1;
                        rcnt_d  = '0;
                    end
                end
                ST_HELD: begin
                    if (rcnt_q == R_LAST) begin
                        repeat_d = 1'b1;
                        rcnt_d   = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            rcnt_q    <= '0;
            state_q   <= ST_IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            rcnt_q    <= rcnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
            repeat_q  <= repeat_d;
        end
    end

    assign LEVEL   = level_q;
    assign PRESS   = press_q;
    assign RELEASE = release_q;
    assign HOLD    = hold_q;
    assign REPEAT  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized button stimulus checked cycle by cycle against a windowed debounce and
// press-timestamp event model.
module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic BTN = 1'b0;
    logic LEVEL, PRESS, RELEASE, HOLD, REPEAT;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    logic m_s1, m_s2, m_level;
    logic hist [DEB];
    int   cyc        = 0;
    int   press_edge = -1;
    logic e_press, e_release, e_hold, e_repeat;

    // Observed DUT event counts for the current phase.
    int c_press, c_release, c_hold, c_repeat;

    always #5 CLK = ~CLK;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .BTN    (BTN),
        .LEVEL  (LEVEL),
        .PRESS  (PRESS),
        .RELEASE(RELEASE),
        .HOLD   (HOLD),
        .REPEAT (REPEAT)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // LEVEL flips once the last DEB synchronised samples all disagree with it; events are
    // timed from the edge that raised LEVEL.
    task automatic model_edge();
        logic all_diff;
        logic new_level;
        int   d;
        cyc++;
        e_press   = 1'b0;
        e_release = 1'b0;
        e_hold    = 1'b0;
        e_repeat  = 1'b0;
        if (RST) begin
            m_s1       = 1'b0;
            m_s2       = 1'b0;
            m_level    = 1'b0;
            press_edge = -1;
            for (int i = 0; i < DEB; i++) hist[i] = 1'b0;
        end else begin
            for (int i = DEB - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0]  = m_s2;
            all_diff = 1'b1;
            for (int i = 0; i < DEB; i++) if (hist[i] == m_level) all_diff = 1'b0;
            new_level = all_diff ? ~m_level : m_level;
            m_s2 = m_s1;
            m_s1 = BTN;
            if (new_level && !m_level) begin
                e_press    = 1'b1;
                press_edge = cyc;
            end else if (!new_level && m_level) begin
                e_release  = 1'b1;
                press_edge = -1;
            end else if (new_level && press_edge >= 0) begin
                d = cyc - press_edge;
                if (d == LONG) e_hold = 1'b1;
                if (d > LONG && ((d - LONG) % REP) == 0) e_repeat = 1'b1;
            end
            m_level = new_level;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        model_edge();
        check("level",   LEVEL,   m_level);
        check("press",   PRESS,   e_press);
        check("release", RELEASE, e_release);
        check("hold",    HOLD,    e_hold);
        check("repeat",  REPEAT,  e_repeat);
        check("onehot", ((int'(PRESS) + int'(RELEASE) + int'(HOLD) + int'(REPEAT)) <= 1), 1'b1);
        if (PRESS === 1'b1)   c_press++;
        if (RELEASE === 1'b1) c_release++;
        if (HOLD === 1'b1)    c_hold++;
        if (REPEAT === 1'b1)  c_repeat++;
    endtask

    task automatic run(input logic b, input int n);
        BTN = b;
        repeat (n) step();
    endtask

    task automatic zero_counts();
        c_press   = 0;
        c_release = 0;
        c_hold    = 0;
        c_repeat  = 0;
    endtask

    task automatic check_counts(input string tag, input int p, input int r, input int h, input int q);
        check_int({tag, "_press_cnt"},   c_press,   p);
        check_int({tag, "_release_cnt"}, c_release, r);
        check_int({tag, "_hold_cnt"},    c_hold,    h);
        check_int({tag, "_repeat_cnt"},  c_repeat,  q);
    endtask

    initial begin
        zero_counts();
        // Reset with button released.
        RST = 1'b1;
        run(1'b0, 3);
        RST = 1'b0;

        // Clean short press.
        zero_counts();
        run(1'b1, 12);
        run(1'b0, 12);
        check_counts("short", 1, 1, 0, 0);

        // Bounce, then a clean press; a 3-cycle glitch afterwards is rejected.
        zero_counts();
        run(1'b1, 2); run(1'b0, 2); run(1'b1, 2); run(1'b0, 2);
        run(1'b1, 12);
        run(1'b0, 12);
        run(1'b1, 3);
        run(1'b0, 10);
        check_counts("bounce", 1, 1, 0, 0);

        // Long press: HOLD at e25, REPEAT at e30/e35/e40, RELEASE at e45 suppresses a repeat.
        zero_counts();
        run(1'b1, 40);
        run(1'b0, 15);
        check_counts("long", 1, 1, 1, 3);

        // Release landing on a REPEAT edge (e35).
        zero_counts();
        run(1'b1, 30);
        run(1'b0, 15);
        check_counts("simul", 1, 1, 1, 1);

        // Reset while HELD with the button still down.
        zero_counts();
        run(1'b1, 30);
        RST = 1'b1;
        run(1'b1, 1);
        RST = 1'b0;
        run(1'b1, 12);
        run(1'b0, 12);
        check_counts("rstmid", 2, 1, 1, 0);

        // Random runs with occasional reset pulses.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 11) == 0) begin
                RST = 1'b1;
                step();
                RST = 1'b0;
            end
            run(logic'($urandom_range(0, 1)), int'($urandom_range(1, 45)));
        end
        run(1'b0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
